// File: rtl/shift_tick_ctrl_if.sv
// rtl/shift_tick_ctrl_if.sv - Control and status bundle between shift_tick_ctrl and its driver.
// The i_btn_pause member exists only when SHIFT_TICK_PAUSE_EN is defined.
interface shift_tick_ctrl_if;
   logic       i_run;
   logic [1:0] i_sel;
   logic       i_btn_dir;
`ifdef SHIFT_TICK_PAUSE_EN
   logic       i_btn_pause;
`endif
   logic       o_shift_enable;
   logic       o_shift_dir;
   logic       o_btn_state;

   modport master (
`ifdef SHIFT_TICK_PAUSE_EN
      output i_btn_pause,
`endif
      output i_run, i_sel, i_btn_dir,
      input  o_shift_enable, o_shift_dir, o_btn_state
   );

   modport slave (
`ifdef SHIFT_TICK_PAUSE_EN
      input  i_btn_pause,
`endif
      input  i_run, i_sel, i_btn_dir,
      output o_shift_enable, o_shift_dir, o_btn_state
   );
endinterface

// File: rtl/shift_tick_ctrl.sv
// rtl/shift_tick_ctrl.sv - Shift-enable prescaler with debounced direction toggle button.
// Optional pause button and pause flag when SHIFT_TICK_PAUSE_EN is defined.

// Synchronizer plus debounce FSM; flag toggles once per accepted press.
module shift_tick_db #(
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic flag
);
   localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

   state_t         state;
   logic [1:0]     sync;
   logic [DBW-1:0] db;
   logic           btn_s;

   assign btn_s = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b00;
         state <= IDLE;
         db    <= '0;
         level <= 1'b0;
         flag  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state <= DB_PRESS;
                  db    <= '0;
               end
            end
            DB_PRESS: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (db == DB_LAST) begin
                  state <= PRESSED;
                  flag  <= ~flag;
                  level <= 1'b1;
               end else begin
                  db <= db + 1'b1;
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  state <= DB_REL;
                  db    <= '0;
               end
            end
            DB_REL: begin
               if (btn_s) begin
                  state <= PRESSED;
               end else if (db == DB_LAST) begin
                  state <= IDLE;
                  level <= 1'b0;
               end else begin
                  db <= db + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

module shift_tick_ctrl #(
   parameter int          N_CNT     = 32,
   parameter int unsigned LIM0      = 12500000,
   parameter int unsigned LIM1      = 25000000,
   parameter int unsigned LIM2      = 50000000,
   parameter int unsigned LIM3      = 100000000,
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               i_ck_rst,
   shift_tick_ctrl_if.slave   bus
);
   logic [N_CNT-1:0] cnt;
   logic [N_CNT-1:0] lim;
   logic             run;

   always_comb begin
      lim = N_CNT'(LIM0);
      case (bus.i_sel)
         2'd0:    lim = N_CNT'(LIM0);
         2'd1:    lim = N_CNT'(LIM1);
         2'd2:    lim = N_CNT'(LIM2);
         default: lim = N_CNT'(LIM3);
      endcase
   end

`ifdef SHIFT_TICK_PAUSE_EN
   logic pause;
   logic pause_level;

   shift_tick_db #(.DB_CYCLES(DB_CYCLES)) u_pause_db (
      .clk   (clk),
      .rst   (i_ck_rst),
      .raw   (bus.i_btn_pause),
      .level (pause_level),
      .flag  (pause)
   );

   assign run = bus.i_run & ~pause;
`else
   assign run = bus.i_run;
`endif

   // ">=" rather than "==" so a shorter period selected mid-count wraps on the next edge.
   always_ff @(posedge clk or posedge i_ck_rst) begin
      if (i_ck_rst) begin
         cnt                <= '0;
         bus.o_shift_enable <= 1'b0;
      end else if (run) begin
         if (cnt >= lim - N_CNT'(1)) begin
            cnt                <= '0;
            bus.o_shift_enable <= 1'b1;
         end else begin
            cnt                <= cnt + N_CNT'(1);
            bus.o_shift_enable <= 1'b0;
         end
      end else begin
         bus.o_shift_enable <= 1'b0;
      end
   end

   shift_tick_db #(.DB_CYCLES(DB_CYCLES)) u_dir_db (
      .clk   (clk),
      .rst   (i_ck_rst),
      .raw   (bus.i_btn_dir),
      .level (bus.o_btn_state),
      .flag  (bus.o_shift_dir)
   );
endmodule
